// File: rtl/sram_bus_bridge_pkg.sv
// Shared types for the SRAM-to-bus bridge: FSM encoding, bus widths, pending-request record.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sram_bus_bridge_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_SW = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_D  = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_REQ_I  = 3'd3,
        ST_WAIT_I = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // One latched core-side SRAM request
    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [BUS_SW-1:0] wen;
        logic [BUS_DW-1:0] wdata;
    } sram_req_t;

    // Any byte-enable set makes the access a write
    function automatic logic is_write(input logic [BUS_SW-1:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/sram_bus_bridge_if.sv
// Single-outstanding request/response bus between the bridge and the memory system.
// Latency: none (wiring only).
// Backpressure: request holds while bus_req_ready is low; response has no ready.
interface sram_bus_bridge_if;
    import sram_bus_bridge_pkg::*;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [BUS_AW-1:0] bus_req_addr;
    logic              bus_req_wr;
    logic [BUS_SW-1:0] bus_req_wstrb;
    logic [BUS_DW-1:0] bus_req_wdata;
    logic              bus_resp_valid;
    logic [BUS_DW-1:0] bus_resp_rdata;

    modport master (
        output bus_req_valid,
        input  bus_req_ready,
        output bus_req_addr,
        output bus_req_wr,
        output bus_req_wstrb,
        output bus_req_wdata,
        input  bus_resp_valid,
        input  bus_resp_rdata
    );

    modport slave (
        input  bus_req_valid,
        output bus_req_ready,
        input  bus_req_addr,
        input  bus_req_wr,
        input  bus_req_wstrb,
        input  bus_req_wdata,
        output bus_resp_valid,
        output bus_resp_rdata
    );

endinterface

// File: rtl/bus_timeout_cnt.sv
// Loadable down-counter that flags expiry when it reaches zero.
// Latency: load takes effect next cycle; expire_o is combinational from the count.
// Backpressure: none; decrement simply stalls at zero.
module bus_timeout_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; never wrap below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_bridge.sv
// Bridges the core's inst/data SRAM ports onto one bus, one transaction in flight, stalling the pipeline meanwhile.
// Latency: request on bus the cycle after en; rdata valid in DONE, the cycle after the response (or timeout).
// Backpressure: bus_req_* held stable until bus_req_ready; core is frozen via stallreq_for_bus.
module sram_bus_bridge
    import sram_bus_bridge_pkg::*;
#(
    parameter int DATA_FIRST  = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [BUS_SW-1:0] inst_sram_wen,
    input  logic [BUS_AW-1:0] inst_sram_addr,
    input  logic [BUS_DW-1:0] inst_sram_wdata,
    output logic [BUS_DW-1:0] inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [BUS_SW-1:0] data_sram_wen,
    input  logic [BUS_AW-1:0] data_sram_addr,
    input  logic [BUS_DW-1:0] data_sram_wdata,
    output logic [BUS_DW-1:0] data_sram_rdata,
    output logic              stallreq_for_bus,
    sram_bus_bridge_if.master bus,
    output logic              bus_timeout
);

    // The counter holds TIMEOUT_CYC-1 at most: it is loaded on the handshake and
    // expires on the TIMEOUT_CYC-th WAIT cycle.
    localparam int               CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              inst_pend_q, inst_pend_d;
    logic              data_pend_q, data_pend_d;
    sram_req_t         inst_req_q, inst_req_d;
    sram_req_t         data_req_q, data_req_d;
    logic [BUS_DW-1:0] inst_rdata_q, inst_rdata_d;
    logic [BUS_DW-1:0] data_rdata_q, data_rdata_d;
    logic              timeout_q, timeout_d;

    logic      accept;
    logic      in_req;
    logic      in_wait;
    logic      req_hs;
    logic      rsp_fire;
    logic      tmo_fire;
    logic      wait_end;
    logic      cnt_expire;
    sram_req_t cur_req;

    assign accept   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign in_req   = (state_q == ST_REQ_D) || (state_q == ST_REQ_I);
    assign in_wait  = (state_q == ST_WAIT_D) || (state_q == ST_WAIT_I);
    assign req_hs   = in_req && bus.bus_req_ready;
    // A real response in the expiry cycle still counts as a response
    assign rsp_fire = in_wait && bus.bus_resp_valid;
    assign tmo_fire = in_wait && !bus.bus_resp_valid && cnt_expire;
    assign wait_end = rsp_fire || tmo_fire;
    assign cur_req  = (state_q == ST_REQ_D) ? data_req_q : inst_req_q;

    bus_timeout_cnt #(
        .CNT_W (CNT_W)
    ) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (req_hs),
        .load_val_i (CNT_LOAD),
        .dec_i      (in_wait),
        .expire_o   (cnt_expire)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: pick a side on accept, then serve the other side if still pending
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (data_sram_en && ((DATA_FIRST != 0) || !inst_sram_en)) begin
                    state_d = ST_REQ_D;
                end else if (inst_sram_en) begin
                    state_d = ST_REQ_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ_D: begin
                if (bus.bus_req_ready) state_d = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                if (wait_end) state_d = inst_pend_q ? ST_REQ_I : ST_DONE;
            end
            ST_REQ_I: begin
                if (bus.bus_req_ready) state_d = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                if (wait_end) state_d = data_pend_q ? ST_REQ_D : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bus request straight from the pending record, zero when not requesting
    always_comb begin
        stallreq_for_bus  = accept ? (inst_sram_en || data_sram_en) : 1'b1;
        bus.bus_req_valid = 1'b0;
        bus.bus_req_addr  = '0;
        bus.bus_req_wr    = 1'b0;
        bus.bus_req_wstrb = '0;
        bus.bus_req_wdata = '0;
        if (in_req) begin
            bus.bus_req_valid = 1'b1;
            bus.bus_req_addr  = cur_req.addr;
            bus.bus_req_wr    = is_write(cur_req.wen);
            bus.bus_req_wstrb = cur_req.wen;
            bus.bus_req_wdata = cur_req.wdata;
        end
    end

    // Datapath next state: latch requests on accept, retire them on response or timeout
    always_comb begin
        inst_pend_d  = inst_pend_q;
        data_pend_d  = data_pend_q;
        inst_req_d   = inst_req_q;
        data_req_d   = data_req_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        timeout_d    = timeout_q;

        if (accept && inst_sram_en) begin
            inst_pend_d      = 1'b1;
            inst_req_d.addr  = inst_sram_addr;
            inst_req_d.wen   = inst_sram_wen;
            inst_req_d.wdata = inst_sram_wdata;
        end
        if (accept && data_sram_en) begin
            data_pend_d      = 1'b1;
            data_req_d.addr  = data_sram_addr;
            data_req_d.wen   = data_sram_wen;
            data_req_d.wdata = data_sram_wdata;
        end

        if (wait_end && (state_q == ST_WAIT_I)) begin
            inst_pend_d = 1'b0;
            if (!is_write(inst_req_q.wen)) begin
                inst_rdata_d = rsp_fire ? bus.bus_resp_rdata : '0;
            end
        end
        if (wait_end && (state_q == ST_WAIT_D)) begin
            data_pend_d = 1'b0;
            if (!is_write(data_req_q.wen)) begin
                data_rdata_d = rsp_fire ? bus.bus_resp_rdata : '0;
            end
        end

        if (tmo_fire) timeout_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_pend_q  <= 1'b0;
            data_pend_q  <= 1'b0;
            inst_req_q   <= '0;
            data_req_q   <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            inst_pend_q  <= inst_pend_d;
            data_pend_q  <= data_pend_d;
            inst_req_q   <= inst_req_d;
            data_req_q   <= data_req_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign bus_timeout     = timeout_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Testbench for sram_bus_bridge: directed corner cases plus randomized core/bus traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: bench varies bus_req_ready delay and response delay, including dropped responses.
`timescale 1ns/1ps
module tb_sram_bus_bridge;
    import sram_bus_bridge_pkg::*;

    localparam int DF  = 1;
    localparam int TMO = 8;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } creq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_for_bus;
    logic        bus_timeout;

    sram_bus_bridge_if bus_if();

    sram_bus_bridge #(
        .DATA_FIRST  (DF),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_wen    (inst_sram_wen),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_for_bus (stallreq_for_bus),
        .bus              (bus_if),
        .bus_timeout      (bus_timeout)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
    logic        exp_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic creq_t mk(input logic en, input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
        creq_t r;
        r.en    = en;
        r.addr  = addr;
        r.wen   = wen;
        r.wdata = wdata;
        return r;
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, "_irdata"}, inst_sram_rdata, exp_irdata);
        chk({tag, "_drdata"}, data_sram_rdata, exp_drdata);
        chk({tag, "_tmo"}, {31'b0, bus_timeout}, {31'b0, exp_tmo});
    endtask

    // One core access cycle (inst and/or data) followed by its bus transactions.
    // Called just after a negedge with the bridge in IDLE or DONE; returns just after
    // a negedge in DONE (b2b) or IDLE.
    task automatic run_txn(input creq_t ir, input creq_t dr, input int rdy_lat, input int rsp_lat,
                           input logic [31:0] rsp0, input logic [31:0] rsp1,
                           input bit drop0, input bit drop1, input bit b2b);
        creq_t       q[$];
        bit          side[$];
        creq_t       r;
        logic [31:0] rsp;
        bit          drop;
        int          nwait;

        // Transaction order follows the arbitration rule
        if (dr.en && (DF != 0 || !ir.en)) begin
            q.push_back(dr); side.push_back(1'b1);
            if (ir.en) begin q.push_back(ir); side.push_back(1'b0); end
        end else begin
            if (ir.en) begin q.push_back(ir); side.push_back(1'b0); end
            if (dr.en) begin q.push_back(dr); side.push_back(1'b1); end
        end

        inst_sram_en = ir.en; inst_sram_addr = ir.addr; inst_sram_wen = ir.wen; inst_sram_wdata = ir.wdata;
        data_sram_en = dr.en; data_sram_addr = dr.addr; data_sram_wen = dr.wen; data_sram_wdata = dr.wdata;
        #1;
        chk("stall_on_en", {31'b0, stallreq_for_bus}, 32'd1);
        @(negedge clk);
        inst_sram_en = 1'b0; inst_sram_addr = $urandom; inst_sram_wen = 4'($urandom); inst_sram_wdata = $urandom;
        data_sram_en = 1'b0; data_sram_addr = $urandom; data_sram_wen = 4'($urandom); data_sram_wdata = $urandom;

        for (int k = 0; k < q.size(); k++) begin
            r     = q[k];
            rsp   = (k == 0) ? rsp0 : rsp1;
            drop  = (k == 0) ? drop0 : drop1;
            for (int c = 0; c <= rdy_lat; c++) begin
                bus_if.bus_req_ready = (c == rdy_lat);
                #1;
                chk("req_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
                chk("req_addr", bus_if.bus_req_addr, r.addr);
                chk("req_wr", {31'b0, bus_if.bus_req_wr}, {31'b0, (r.wen != 4'h0)});
                chk("req_wstrb", {28'b0, bus_if.bus_req_wstrb}, {28'b0, r.wen});
                chk("req_wdata", bus_if.bus_req_wdata, r.wdata);
                chk("req_stall", {31'b0, stallreq_for_bus}, 32'd1);
                @(negedge clk);
            end
            bus_if.bus_req_ready = 1'b0;
            nwait = drop ? TMO : (rsp_lat + 1);
            for (int c = 0; c < nwait; c++) begin
                if (!drop && (c == rsp_lat)) begin
                    bus_if.bus_resp_valid = 1'b1;
                    bus_if.bus_resp_rdata = rsp;
                end else begin
                    bus_if.bus_resp_valid = 1'b0;
                    bus_if.bus_resp_rdata = $urandom;
                end
                #1;
                chk("wait_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
                chk("wait_stall", {31'b0, stallreq_for_bus}, 32'd1);
                chk_regs("wait_hold");
                @(negedge clk);
            end
            bus_if.bus_resp_valid = 1'b0;
            if (r.wen == 4'h0) begin
                if (side[k]) exp_drdata = drop ? 32'h0 : rsp;
                else         exp_irdata = drop ? 32'h0 : rsp;
            end
            if (drop) exp_tmo = 1'b1;
        end

        #1;
        chk("done_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
        chk_regs("done");
        if (!b2b) begin
            chk("done_stall", {31'b0, stallreq_for_bus}, 32'd0);
            @(negedge clk);
            #1;
            chk("idle_stall", {31'b0, stallreq_for_bus}, 32'd0);
            chk_regs("idle");
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        bus_if.bus_req_ready = 1'b0; bus_if.bus_resp_valid = 1'b0; bus_if.bus_resp_rdata = 32'h0;
        exp_irdata = 32'h0; exp_drdata = 32'h0; exp_tmo = 1'b0;

        // Reset state
        #3;
        chk("rst_stall", {31'b0, stallreq_for_bus}, 32'd0);
        chk("rst_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
        chk("rst_addr", bus_if.bus_req_addr, 32'h0);
        chk("rst_wr", {31'b0, bus_if.bus_req_wr}, 32'd0);
        chk("rst_wstrb", {28'b0, bus_if.bus_req_wstrb}, 32'd0);
        chk("rst_wdata", bus_if.bus_req_wdata, 32'h0);
        chk_regs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Inst read, immediate ready, response in first WAIT cycle
        run_txn(mk(1'b1, 32'hBFC00000, 4'h0, 32'h0), mk(1'b0, 32'h0, 4'h0, 32'h0),
                0, 0, 32'h3C080001, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("inst_read_value", inst_sram_rdata, 32'h3C080001);

        // Simultaneous inst read + data write: data write goes first
        run_txn(mk(1'b1, 32'hBFC00004, 4'h0, 32'h0), mk(1'b1, 32'h80000010, 4'hF, 32'h12345678),
                0, 1, 32'hA5A5A5A5, 32'h24020013, 1'b0, 1'b0, 1'b0);
        chk("simul_inst_value", inst_sram_rdata, 32'h24020013);
        chk("simul_data_unchanged", data_sram_rdata, 32'h0);

        // Backpressure: ready low for 5 cycles
        run_txn(mk(1'b0, 32'h0, 4'h0, 32'h0), mk(1'b1, 32'h80000020, 4'h0, 32'h0),
                5, 2, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0);

        // Timeout: no response on an inst read
        run_txn(mk(1'b1, 32'hBFC00008, 4'h0, 32'h0), mk(1'b0, 32'h0, 4'h0, 32'h0),
                0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("timeout_flag", {31'b0, bus_timeout}, 32'd1);
        chk("timeout_rdata", inst_sram_rdata, 32'h0);

        // Back-to-back: second request presented in DONE
        run_txn(mk(1'b0, 32'h0, 4'h0, 32'h0), mk(1'b1, 32'h80000030, 4'h0, 32'h0),
                0, 1, 32'h11112222, 32'h0, 1'b0, 1'b0, 1'b1);
        run_txn(mk(1'b0, 32'h0, 4'h0, 32'h0), mk(1'b1, 32'h80000034, 4'h0, 32'h0),
                1, 3, 32'h33334444, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("b2b_data_value", data_sram_rdata, 32'h33334444);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            creq_t ir, dr;
            bit    ie, de;
            ie = 1'($urandom_range(0, 1));
            de = ie ? 1'($urandom_range(0, 1)) : 1'b1;
            ir = mk(ie, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom);
            dr = mk(de, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom);
            run_txn(ir, dr, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), $urandom, $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) != 0));
        end

        // Reset while waiting on a data read, then a stale response
        data_sram_en = 1'b1; data_sram_addr = 32'h80000040; data_sram_wen = 4'h0; data_sram_wdata = 32'h0;
        @(negedge clk);
        data_sram_en = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        #1;
        chk("rstw_req_valid", {31'b0, bus_if.bus_req_valid}, 32'd1);
        @(negedge clk);
        bus_if.bus_req_ready = 1'b0;
        #1;
        rst = 1'b1;
        exp_irdata = 32'h0; exp_drdata = 32'h0; exp_tmo = 1'b0;
        #1;
        chk("rstw_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
        chk("rstw_addr", bus_if.bus_req_addr, 32'h0);
        chk("rstw_stall", {31'b0, stallreq_for_bus}, 32'd0);
        chk_regs("rstw");
        @(negedge clk);
        rst = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_resp_rdata = 32'hDEADBEEF;
        #1;
        chk("stale_valid", {31'b0, bus_if.bus_req_valid}, 32'd0);
        chk("stale_stall", {31'b0, stallreq_for_bus}, 32'd0);
        @(negedge clk);
        bus_if.bus_resp_valid = 1'b0;
        #1;
        chk_regs("stale");

        // Normal operation after the abandoned transaction
        run_txn(mk(1'b1, 32'hBFC00010, 4'h0, 32'h0), mk(1'b1, 32'h80000044, 4'h0, 32'h0),
                2, 1, 32'h0BADF00D, 32'h5EED1234, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
